// File: rtl/dino_pkg.sv
// dino_pkg: shared encodings for the dino player block.
//   - FSM state codes (3-bit, matching the width of o_state)
//   - sprite frame IDs used to address the sprite ROM
//   - sprite geometry: 16x16 bitmap drawn at 2x scale into a 32x32 box
//   - frame_for_state(): picks the sprite frame for the current player state
package dino_pkg;

    localparam logic [2:0] ST_RUN  = 3'd0;
    localparam logic [2:0] ST_AIR  = 3'd1;
    localparam logic [2:0] ST_DUCK = 3'd2;
    localparam logic [2:0] ST_DEAD = 3'd3;

    localparam logic [1:0] FR_RUN0 = 2'd0;
    localparam logic [1:0] FR_RUN1 = 2'd1;
    localparam logic [1:0] FR_DUCK = 2'd2;
    localparam logic [1:0] FR_DEAD = 2'd3;

    localparam int SPRITE_W     = 16;
    localparam int SPRITE_SCALE = 2;
    localparam int BOX_W        = SPRITE_W * SPRITE_SCALE;

    typedef logic [SPRITE_W-1:0] sprite_row_t;

    // A latched death always shows the DEAD frame, even before the state
    // register has been decoded; otherwise the frame follows the state.
    function automatic logic [1:0] frame_for_state(input logic [2:0] st,
                                                   input logic       run_frame,
                                                   input logic       dead);
        logic [1:0] fr;
        fr = FR_DEAD;
        if (!dead) begin
            case (st)
                ST_RUN:  fr = run_frame ? FR_RUN1 : FR_RUN0;
                ST_AIR:  fr = FR_RUN0;
                ST_DUCK: fr = FR_DUCK;
                default: fr = FR_DEAD;
            endcase
        end
        return fr;
    endfunction

endpackage

// File: rtl/dino_player_sprite_rom.sv
// player_sprite_rom: combinational 4-frame x 16-row x 16-column sprite ROM.
//   frame [1:0] : sprite frame ID (RUN0, RUN1, DUCK, DEAD)
//   row   [3:0] : bitmap row, 0 = top
//   col   [3:0] : bitmap column, 0 = left
//   pixel       : 1 = opaque
// Each row word is stored left-to-right, so column 0 is bit 15.
module player_sprite_rom
    import dino_pkg::*;
(
    input  logic [1:0] frame,
    input  logic [3:0] row,
    input  logic [3:0] col,
    output logic       pixel
);

    sprite_row_t row_bits;

    always_comb begin
        row_bits = '0;
        case ({frame, row})
            // RUN0
            6'h00: row_bits = 16'h00FE;
            6'h01: row_bits = 16'h01BF;
            6'h02: row_bits = 16'h01FF;
            6'h03: row_bits = 16'h01F0;
            6'h04: row_bits = 16'h01FC;
            6'h05: row_bits = 16'h83E0;
            6'h06: row_bits = 16'hC7E0;
            6'h07: row_bits = 16'hFFF8;
            6'h08: row_bits = 16'hFFE8;
            6'h09: row_bits = 16'h7FE0;
            6'h0A: row_bits = 16'h3FC0;
            6'h0B: row_bits = 16'h1F80;
            6'h0C: row_bits = 16'h0F00;
            6'h0D: row_bits = 16'h0C80;
            6'h0E: row_bits = 16'h0800;
            6'h0F: row_bits = 16'h0C00;
            // RUN1: same body, other leg forward
            6'h10: row_bits = 16'h00FE;
            6'h11: row_bits = 16'h01BF;
            6'h12: row_bits = 16'h01FF;
            6'h13: row_bits = 16'h01F0;
            6'h14: row_bits = 16'h01FC;
            6'h15: row_bits = 16'h83E0;
            6'h16: row_bits = 16'hC7E0;
            6'h17: row_bits = 16'hFFF8;
            6'h18: row_bits = 16'hFFE8;
            6'h19: row_bits = 16'h7FE0;
            6'h1A: row_bits = 16'h3FC0;
            6'h1B: row_bits = 16'h1F80;
            6'h1C: row_bits = 16'h0F00;
            6'h1D: row_bits = 16'h0480;
            6'h1E: row_bits = 16'h0080;
            6'h1F: row_bits = 16'h00C0;
            // DUCK: rows 0..8 are empty (default)
            6'h29: row_bits = 16'hC07E;
            6'h2A: row_bits = 16'hFFDF;
            6'h2B: row_bits = 16'hFFFF;
            6'h2C: row_bits = 16'h7FF8;
            6'h2D: row_bits = 16'h3FFC;
            6'h2E: row_bits = 16'h1980;
            6'h2F: row_bits = 16'h1100;
            // DEAD: crossed-out eye, both legs down
            6'h30: row_bits = 16'h00FE;
            6'h31: row_bits = 16'h01D7;
            6'h32: row_bits = 16'h01EF;
            6'h33: row_bits = 16'h01D7;
            6'h34: row_bits = 16'h01FC;
            6'h35: row_bits = 16'h83E0;
            6'h36: row_bits = 16'hC7E0;
            6'h37: row_bits = 16'hFFF8;
            6'h38: row_bits = 16'hFFE8;
            6'h39: row_bits = 16'h7FE0;
            6'h3A: row_bits = 16'h3FC0;
            6'h3B: row_bits = 16'h1F80;
            6'h3C: row_bits = 16'h0F00;
            6'h3D: row_bits = 16'h0D80;
            6'h3E: row_bits = 16'h0880;
            6'h3F: row_bits = 16'h0CC0;
            default: row_bits = '0;
        endcase
    end

    assign pixel = row_bits[4'(SPRITE_W - 1) - col];

endmodule

// File: rtl/dino_player.sv
// dino_player: player state machine, jump physics, run animation and
// per-pixel sprite output for the dino game.
//   clk              : pixel clock
//   rst              : asynchronous active-high reset
//   i_game_tick_60hz : one-cycle frame pulse (beam at 0,0); physics step
//   i_jump           : jump button (level or pulse; pulses are remembered)
//   i_duck           : duck button (level)
//   i_restart        : leave DEAD (sampled every cycle)
//   i_collision      : collision flag from graphics_top
//   i_hpos, i_vpos   : current beam column / row
//   o_color_player   : sprite opaque at the beam position (combinational)
//   o_state          : RUN=0, AIR=1, DUCK=2, DEAD=3
//   o_height         : sprite height above the ground in pixels
module dino_player
    import dino_pkg::*;
#(
    parameter int PLAYER_X    = 64,
    parameter int GROUND_Y    = 400,
    parameter int JUMP_VEL    = 15,
    parameter int GRAVITY     = 1,
    parameter int ANIM_FRAMES = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_game_tick_60hz,
    input  logic       i_jump,
    input  logic       i_duck,
    input  logic       i_restart,
    input  logic       i_collision,
    input  logic [9:0] i_hpos,
    input  logic [9:0] i_vpos,
    output logic       o_color_player,
    output logic [2:0] o_state,
    output logic [6:0] o_height
);

    localparam int                CNT_W     = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
    localparam logic [CNT_W-1:0]  ANIM_LAST = CNT_W'(ANIM_FRAMES - 1);
    localparam logic signed [5:0] JUMP_V    = 6'(JUMP_VEL);
    localparam logic [10:0]       BOX_X0    = 11'(PLAYER_X);
    localparam logic [10:0]       BOX_SZ    = 11'(BOX_W);
    localparam logic [10:0]       GROUND    = 11'(GROUND_Y);

    // Velocity minus gravity, clamped to the 6-bit signed range so a long
    // fall pins at -32 instead of wrapping to a large upward speed.
    function automatic logic signed [5:0] vel_sat_sub(input logic signed [5:0] v,
                                                     input int               g);
        int d;
        d = int'(v) - g;
        if (d < -32)
            return 6'sb100000;
        else if (d > 31)
            return 6'sb011111;
        else
            return 6'(d);
    endfunction

    logic [2:0]        state;
    logic [6:0]        height;
    logic signed [5:0] vel;
    logic              jump_pending;
    logic [CNT_W-1:0]  anim_cnt;
    logic              run_frame;
    logic              dead_latched;

    logic              jump_req;
    logic signed [7:0] sum_air;
    logic              air_lands;
    logic signed [5:0] vel_next;

    assign jump_req  = jump_pending | i_jump;
    assign sum_air   = $signed({1'b0, height}) + $signed({{2{vel[5]}}, vel});
    assign air_lands = sum_air[7] | (sum_air == 8'sd0);
    assign vel_next  = vel_sat_sub(vel, GRAVITY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_RUN;
            height       <= '0;
            vel          <= '0;
            jump_pending <= 1'b0;
            anim_cnt     <= '0;
            run_frame    <= 1'b0;
            dead_latched <= 1'b0;
        end else begin
            // A tick consumes any remembered press; between ticks presses accumulate.
            jump_pending <= i_game_tick_60hz ? 1'b0 : jump_req;

            if (i_collision && (state != ST_DEAD)) begin
                // Collision wins over a same-cycle tick: no physics this cycle.
                state        <= ST_DEAD;
                dead_latched <= 1'b1;
            end else if (state == ST_DEAD) begin
                if (i_restart) begin
                    state        <= ST_RUN;
                    height       <= '0;
                    vel          <= '0;
                    anim_cnt     <= '0;
                    dead_latched <= 1'b0;
                end
            end else if (i_game_tick_60hz) begin
                case (state)
                    ST_RUN: begin
                        if (anim_cnt == ANIM_LAST) begin
                            anim_cnt  <= '0;
                            run_frame <= ~run_frame;
                        end else begin
                            anim_cnt <= anim_cnt + 1'b1;
                        end
                        if (jump_req) begin
                            vel    <= JUMP_V;
                            height <= '0;
                            state  <= ST_AIR;
                        end else if (i_duck) begin
                            state <= ST_DUCK;
                        end
                    end
                    ST_DUCK: begin
                        if (jump_req) begin
                            vel    <= JUMP_V;
                            height <= '0;
                            state  <= ST_AIR;
                        end else if (!i_duck) begin
                            state <= ST_RUN;
                        end
                    end
                    ST_AIR: begin
                        if (air_lands) begin
                            height <= '0;
                            vel    <= '0;
                            state  <= ST_RUN;
                        end else begin
                            height <= sum_air[6:0];
                            vel    <= vel_next;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Sprite box in 11-bit unsigned space so the bounds never wrap.
    logic [10:0] hpos_w;
    logic [10:0] vpos_w;
    logic [10:0] box_top;
    logic [10:0] dx;
    logic [10:0] dy;
    logic        in_box;
    logic [1:0]  frame;
    logic        rom_pixel;
    logic        unused_bits;

    assign hpos_w  = {1'b0, i_hpos};
    assign vpos_w  = {1'b0, i_vpos};
    assign box_top = GROUND - BOX_SZ - {4'b0, height};
    assign dx      = hpos_w - BOX_X0;
    assign dy      = vpos_w - box_top;
    assign in_box  = (hpos_w >= BOX_X0) && (hpos_w < BOX_X0 + BOX_SZ) &&
                     (vpos_w >= box_top) && (vpos_w < box_top + BOX_SZ);

    // Inside the box the offset is 0..31; dropping bit 0 undoes the 2x scale.
    assign unused_bits = ^{dx[10:5], dx[0], dy[10:5], dy[0]};

    assign frame = frame_for_state(state, run_frame, dead_latched);

    player_sprite_rom u_rom (
        .frame (frame),
        .row   (dy[4:1]),
        .col   (dx[4:1]),
        .pixel (rom_pixel)
    );

    assign o_color_player = in_box & rom_pixel;
    assign o_state        = state;
    assign o_height       = height;

endmodule

// File: tb/tb_dino_player.sv
module tb_dino_player;

    localparam int PX = 64, GY = 400, JV = 15, GR = 1, AF = 6, BOX = 32;

    // Sprite bitmaps, row words left-to-right (column 0 = bit 15).
    localparam logic [15:0] ROM [64] = '{
        16'h00FE,16'h01BF,16'h01FF,16'h01F0,16'h01FC,16'h83E0,16'hC7E0,16'hFFF8,
        16'hFFE8,16'h7FE0,16'h3FC0,16'h1F80,16'h0F00,16'h0C80,16'h0800,16'h0C00,
        16'h00FE,16'h01BF,16'h01FF,16'h01F0,16'h01FC,16'h83E0,16'hC7E0,16'hFFF8,
        16'hFFE8,16'h7FE0,16'h3FC0,16'h1F80,16'h0F00,16'h0480,16'h0080,16'h00C0,
        16'h0000,16'h0000,16'h0000,16'h0000,16'h0000,16'h0000,16'h0000,16'h0000,
        16'h0000,16'hC07E,16'hFFDF,16'hFFFF,16'h7FF8,16'h3FFC,16'h1980,16'h1100,
        16'h00FE,16'h01D7,16'h01EF,16'h01D7,16'h01FC,16'h83E0,16'hC7E0,16'hFFF8,
        16'hFFE8,16'h7FE0,16'h3FC0,16'h1F80,16'h0F00,16'h0D80,16'h0880,16'h0CC0
    };

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_tick = 1'b0, in_jump = 1'b0, in_duck = 1'b0;
    logic       in_restart = 1'b0, in_coll = 1'b0;
    logic [9:0] hpos = '0, vpos = '0;
    logic       o_color_player;
    logic [2:0] o_state;
    logic [6:0] o_height;

    always #5 clk = ~clk;

    dino_player #(
        .PLAYER_X(PX), .GROUND_Y(GY), .JUMP_VEL(JV), .GRAVITY(GR), .ANIM_FRAMES(AF)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_game_tick_60hz (in_tick),
        .i_jump           (in_jump),
        .i_duck           (in_duck),
        .i_restart        (in_restart),
        .i_collision      (in_coll),
        .i_hpos           (hpos),
        .i_vpos           (vpos),
        .o_color_player   (o_color_player),
        .o_state          (o_state),
        .o_height         (o_height)
    );

    typedef struct packed {
        logic [2:0] st;
        logic [6:0] h;
        logic       px;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Reference model: state plus jump progress (ticks since take-off) and
    // the total number of RUN ticks, from which height and animation follow.
    int m_st, m_h, m_k, m_rt;
    bit m_pend;
    bit d_lvl;

    // Height after k airborne ticks: sum of the velocities JV, JV-GR, ...
    function automatic int air_h(input int k);
        return k * JV - GR * k * (k - 1) / 2;
    endfunction

    function automatic bit exp_px(input int x, input int y);
        int top, fr, r, c;
        logic [15:0] w;
        top = GY - BOX - m_h;
        if (x < PX || x >= PX + BOX || y < top || y >= top + BOX) return 1'b0;
        case (m_st)
            0:       fr = (m_rt / AF) % 2;
            1:       fr = 0;
            2:       fr = 2;
            default: fr = 3;
        endcase
        r = (y - top) / 2;
        c = (x - PX) / 2;
        w = ROM[fr * 16 + r];
        return w[15 - c];
    endfunction

    task automatic model_reset();
        m_st = 0; m_h = 0; m_k = 0; m_rt = 0; m_pend = 1'b0;
    endtask

    // Applies the inputs that were present at the clock edge just taken.
    task automatic model_clock();
        bit pend_next, jreq;
        if (rst) begin
            model_reset();
            return;
        end
        jreq      = m_pend | in_jump;
        pend_next = in_tick ? 1'b0 : jreq;
        if (m_st != 3 && in_coll) begin
            m_st = 3;
        end else if (m_st == 3) begin
            if (in_restart) begin
                m_st = 0; m_h = 0;
                m_rt = (m_rt / AF) * AF;
            end
        end else if (in_tick) begin
            case (m_st)
                0: begin
                    m_rt++;
                    if (jreq) begin m_st = 1; m_k = 0; m_h = 0; end
                    else if (in_duck) m_st = 2;
                end
                2: begin
                    if (jreq) begin m_st = 1; m_k = 0; m_h = 0; end
                    else if (!in_duck) m_st = 0;
                end
                default: begin
                    m_k++;
                    if (air_h(m_k) <= 0) begin m_st = 0; m_h = 0; end
                    else m_h = air_h(m_k);
                end
            endcase
        end
        m_pend = pend_next;
    endtask

    task automatic chk(input string nm, input int act, input int ex);
        n_vec++;
        if (act != ex) begin
            n_miss++;
            $display("FAIL %s got=%0d want=%0d at t=%0t", nm, act, ex, $time);
        end
    endtask

    // Monitor: one expected record per cycle, checked mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("state", int'(o_state), int'(e.st));
            chk("height", int'(o_height), int'(e.h));
            chk("pixel", int'(o_color_player), int'(e.px));
        end
    end

    function automatic int rx();
        return int'($urandom_range(56, 103));
    endfunction

    function automatic int ry();
        int top;
        top = GY - BOX - m_h;
        return int'($urandom_range(top - 6, top + 37));
    endfunction

    task automatic step(input bit t, input bit j, input bit c, input bit r,
                        input bit rs, input int x, input int y);
        exp_t e;
        @(posedge clk);
        #1;
        model_clock();
        in_tick = t; in_jump = j; in_duck = d_lvl; in_coll = c;
        in_restart = r; rst = rs;
        hpos = 10'(x); vpos = 10'(y);
        if (rs) model_reset();
        e.st = 3'(m_st);
        e.h  = 7'(m_h);
        e.px = exp_px(x, y);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, rx(), ry());
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            step(1, 0, 0, 0, 0, rx(), ry());
            idle(3);
        end
    endtask

    initial begin
        d_lvl = 1'b0;
        model_reset();
        step(0, 0, 0, 0, 1, rx(), ry());
        step(0, 0, 0, 0, 1, rx(), ry());
        step(0, 0, 0, 0, 0, rx(), ry());

        // Scan the area around the grounded sprite.
        for (int y = 360; y < 408; y++)
            for (int x = 56; x < 104; x++)
                step(0, 0, 0, 0, 0, x, y);

        // Single-cycle jump pulse between ticks, full arc to landing.
        idle(5);
        step(0, 1, 0, 0, 0, rx(), ry());
        idle(10);
        ticks(33);

        // Duck, jump out of duck, land still ducking, release.
        d_lvl = 1'b1;
        idle(2);
        ticks(2);
        step(0, 1, 0, 0, 0, rx(), ry());
        ticks(33);
        d_lvl = 1'b0;
        ticks(2);

        // Collision on the same cycle as a tick while airborne, then restart.
        step(0, 1, 0, 0, 0, rx(), ry());
        ticks(4);
        step(1, 0, 1, 0, 0, rx(), ry());
        idle(3);
        ticks(10);
        step(0, 0, 0, 1, 0, rx(), ry());
        idle(3);

        // Run animation over 12 ticks.
        ticks(12);

        // Reset asserted between ticks in the middle of a jump.
        step(0, 1, 0, 0, 0, rx(), ry());
        ticks(7);
        idle(1);
        step(0, 0, 0, 0, 1, rx(), ry());
        step(0, 0, 0, 0, 1, rx(), ry());
        step(0, 0, 0, 0, 0, rx(), ry());
        ticks(3);

        // Randomized traffic.
        for (int cyc = 0; cyc < 16000; cyc++) begin
            bit t, j, c, r;
            int x, y;
            t = (cyc % 16) == 0;
            j = $urandom_range(0, 199) == 0;
            c = $urandom_range(0, 2999) == 0;
            r = $urandom_range(0, 63) == 0;
            if ($urandom_range(0, 299) == 0) d_lvl = ~d_lvl;
            if ($urandom_range(0, 3) == 0) begin
                x = int'($urandom_range(0, 1023));
                y = int'($urandom_range(0, 1023));
            end else begin
                x = rx();
                y = ry();
            end
            step(t, j, c, r, 0, x, y);
        end

        repeat (3) @(negedge clk);
        #1;
        chk("drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
